// File: rtl/iobus_uart_tx.sv
// rtl/iobus_uart_tx.sv - OTTER IOBUS memory-mapped UART transmitter, 8N1 LSB first
// Registers: +0 DATA (push), +4 STATUS (W1C overflow), +8 DIV (bit period).
module iobus_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h1100_0100,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  output logic        TX,
  output logic        TX_BUSY
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e        state_q, state_d;
  logic [15:0]   baud_q, baud_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [15:0]   bit_div_q, bit_div_d;
  logic          tx_q, tx_d;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          ovf_q;
  logic [15:0]   div_q;

  logic sel_data, sel_stat, sel_div;
  logic full, empty, push, pop, ovf_set, bit_end;
  logic [15:0] eff_div;
  logic unused_bits;

  assign sel_data = (IOBUS_ADDR == BASE_ADDR);
  assign sel_stat = (IOBUS_ADDR == BASE_ADDR + 32'd4);
  assign sel_div  = (IOBUS_ADDR == BASE_ADDR + 32'd8);

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  // Full is judged before the edge, so a same-edge pop never rescues a write into a full FIFO.
  assign push    = IOBUS_WR && sel_data && !full;
  assign ovf_set = IOBUS_WR && sel_data && full;
  assign eff_div = (div_q == 16'd0) ? 16'd1 : div_q;
  assign bit_end = (baud_q == bit_div_q - 16'd1);

  assign TX      = tx_q;
  assign TX_BUSY = (state_q != S_IDLE);
  assign unused_bits = ^IOBUS_OUT[31:16];

  always_comb begin
    IOBUS_IN = 32'd0;
    if (sel_stat)
      IOBUS_IN = {16'd0, 8'(count_q), 4'd0, ovf_q, TX_BUSY, empty, full};
    else if (sel_div)
      IOBUS_IN = {16'd0, div_q};
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    bit_div_d = bit_div_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          shift_d   = mem_q[rd_ptr_q];
          bit_div_d = eff_div;
          baud_d    = 16'd0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          baud_d    = 16'd0;
          bit_cnt_d = 3'd0;
          state_d   = S_DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d = 16'd0;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          baud_d = 16'd0;
          if (!empty) begin
            pop       = 1'b1;
            shift_d   = mem_q[rd_ptr_q];
            bit_div_d = eff_div;
            state_d   = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // TX is registered from the next state so the line moves on the same edge as the FSM.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= IOBUS_OUT[7:0];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      baud_q    <= 16'd0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'd0;
      bit_div_q <= 16'd1;
      tx_q      <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      div_q     <= DEFAULT_DIV;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      bit_div_q <= bit_div_d;
      tx_q      <= tx_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (ovf_set)
        ovf_q <= 1'b1;
      else if (IOBUS_WR && sel_stat && IOBUS_OUT[3])
        ovf_q <= 1'b0;
      if (IOBUS_WR && sel_div) div_q <= IOBUS_OUT[15:0];
    end
  end

endmodule

// File: tb/tb_iobus_uart_tx.sv
// tb/tb_iobus_uart_tx.sv - directed self-checking bench for iobus_uart_tx
// Line activity is recorded as {busy, tx} per cycle and compared to a hand-built waveform.
module tb_iobus_uart_tx;

  localparam logic [31:0] BASE = 32'h1100_0100;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] IOBUS_ADDR = 32'd0;
  logic [31:0] IOBUS_OUT = 32'd0;
  logic        IOBUS_WR = 1'b0;
  logic [31:0] IOBUS_IN;
  logic        TX;
  logic        TX_BUSY;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] rd;
  logic [1:0]  exp_q[$];
  logic [1:0]  rec_q[$];

  iobus_uart_tx dut (
    .CLK        (CLK),
    .RST        (RST),
    .IOBUS_ADDR (IOBUS_ADDR),
    .IOBUS_OUT  (IOBUS_OUT),
    .IOBUS_WR   (IOBUS_WR),
    .IOBUS_IN   (IOBUS_IN),
    .TX         (TX),
    .TX_BUSY    (TX_BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    IOBUS_ADDR = a;
    IOBUS_OUT  = d;
    IOBUS_WR   = 1'b1;
    @(negedge CLK);
    IOBUS_WR   = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    IOBUS_ADDR = a;
    #1;
    d = IOBUS_IN;
  endtask

  task automatic add_idle(input int n);
    repeat (n) exp_q.push_back(2'b01);
  endtask

  task automatic add_frame(input logic [7:0] b, input int div);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++)
      repeat (div) exp_q.push_back({1'b1, f[i]});
  endtask

  task automatic record();
    int n;
    n = exp_q.size();
    rec_q.delete();
    repeat (n) begin
      rec_q.push_back({TX_BUSY, TX});
      @(negedge CLK);
    end
  endtask

  task automatic compare(input string tag);
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s[%0d]", tag, i), 32'(rec_q[i]), 32'(exp_q[i]));
    exp_q.delete();
  endtask

  initial begin
    // 1: reset state
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    bus_rd(BASE + 32'd4, rd); check("t1_status", rd, 32'h0000_0002);
    bus_rd(BASE + 32'd8, rd); check("t1_div", rd, 32'h0000_0364);
    check("t1_tx", 32'(TX), 32'd1);
    check("t1_busy", 32'(TX_BUSY), 32'd0);
    @(negedge CLK);

    // 2: single frame 0xA5, 4-cycle bits
    bus_wr(BASE + 32'd8, 32'd4);
    add_idle(2); add_frame(8'hA5, 4); add_idle(4);
    fork
      bus_wr(BASE, 32'h0000_00A5);
      record();
    join
    compare("t2_wave");
    bus_rd(BASE + 32'd4, rd); check("t2_status", rd, 32'h0000_0002);

    // 3: 9 bytes fill FIFO, 10th overflows, frames back-to-back
    bus_wr(BASE + 32'd8, 32'd2);
    add_idle(2);
    for (int b = 1; b <= 9; b++) add_frame(8'(b), 2);
    add_idle(8);
    fork
      begin
        for (int i = 1; i <= 10; i++) bus_wr(BASE, 32'(i));
        bus_rd(BASE + 32'd4, rd); check("t3_status_ovf", rd, 32'h0000_080D);
        bus_wr(BASE + 32'd4, 32'h0000_0008);
        bus_rd(BASE + 32'd4, rd); check("t3_status_clr", rd, 32'h0000_0805);
      end
      record();
    join
    compare("t3_wave");
    bus_rd(BASE + 32'd4, rd); check("t3_status_end", rd, 32'h0000_0002);

    // 4: DIV change mid-frame applies to the next frame only
    bus_wr(BASE + 32'd8, 32'd3);
    add_idle(2); add_frame(8'h00, 3); add_frame(8'h3C, 5); add_idle(8);
    fork
      begin
        bus_wr(BASE, 32'h0000_0000);
        bus_wr(BASE, 32'h0000_003C);
        repeat (5) @(negedge CLK);
        bus_wr(BASE + 32'd8, 32'd5);
        bus_rd(BASE + 32'd8, rd); check("t4_div_rd", rd, 32'd5);
      end
      record();
    join
    compare("t4_wave");

    // 5: reset mid-frame with 3 bytes queued
    bus_wr(BASE + 32'd8, 32'd4);
    bus_wr(BASE, 32'h11);
    bus_wr(BASE, 32'h22);
    bus_wr(BASE, 32'h33);
    bus_wr(BASE, 32'h44);
    bus_rd(BASE + 32'd4, rd); check("t5_status_q", rd, 32'h0000_0304);
    repeat (4) @(negedge CLK);
    check("t5_busy_pre", 32'(TX_BUSY), 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("t5_tx", 32'(TX), 32'd1);
    check("t5_busy", 32'(TX_BUSY), 32'd0);
    bus_rd(BASE + 32'd4, rd); check("t5_status", rd, 32'h0000_0002);
    bus_rd(BASE + 32'd8, rd); check("t5_div", rd, 32'd868);
    add_idle(40);
    record();
    compare("t5_idle");

    // 6: unmapped and misaligned accesses, then DIV=0
    bus_rd(BASE + 32'h0C, rd);  check("t6_rd_0c", rd, 32'd0);
    bus_rd(BASE + 32'h200, rd); check("t6_rd_200", rd, 32'd0);
    bus_rd(BASE + 32'h01, rd);  check("t6_rd_mis", rd, 32'd0);
    bus_wr(BASE + 32'h0C, 32'hFFFF_FFFF);
    bus_wr(BASE + 32'h200, 32'hFFFF_FFFF);
    bus_wr(BASE + 32'h01, 32'hFFFF_FFFF);
    bus_rd(BASE + 32'd4, rd); check("t6_status", rd, 32'h0000_0002);
    bus_rd(BASE + 32'd8, rd); check("t6_div", rd, 32'd868);
    add_idle(12);
    record();
    compare("t6_idle");
    bus_wr(BASE + 32'd8, 32'd0);
    bus_rd(BASE + 32'd8, rd); check("t6_div0", rd, 32'd0);
    add_idle(2); add_frame(8'h5A, 1); add_idle(3);
    fork
      bus_wr(BASE, 32'h0000_005A);
      record();
    join
    compare("t6_wave");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
